hamming_syndrome_fix_pipe: RTL and testbench

// Parametrised successor of the 4-to-16 syndrome decoder in the Hamming decoder datapath.

---
 rtl/hamming_syndrome_fix_pipe_if.sv | 31 +++
 rtl/hamming_syndrome_fix_pipe.sv | 129 ++++++++++++
 tb/tb_hamming_syndrome_fix_pipe.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hamming_syndrome_fix_pipe_if.sv
// Stream and status bundle for the Hamming syndrome fix pipeline.
// The master side drives the input beat, output backpressure and counter clear.
interface hamming_syndrome_fix_pipe_if #(
    parameter int SYN_W = 4,
    parameter int CNT_W = 16
);
    localparam int CW_W = (1 << SYN_W) - 1;

    logic             in_valid;
    logic             in_ready;
    logic [CW_W:1]    in_codeword;
    logic [SYN_W-1:0] in_syndrome;
    logic             in_bypass;
    logic             out_valid;
    logic             out_ready;
    logic [CW_W:1]    out_codeword;
    logic             out_err;
    logic [SYN_W-1:0] out_err_pos;
    logic [CNT_W-1:0] err_count;
    logic             clr_count;

    modport master (
        output in_valid, in_codeword, in_syndrome, in_bypass, out_ready, clr_count,
        input  in_ready, out_valid, out_codeword, out_err, out_err_pos, err_count
    );

    modport slave (
        input  in_valid, in_codeword, in_syndrome, in_bypass, out_ready, clr_count,
        output in_ready, out_valid, out_codeword, out_err, out_err_pos, err_count
    );
endinterface

// File: rtl/hamming_syndrome_fix_pipe.sv
// Two-stage valid/ready pipeline: decodes a syndrome into a one-hot flip mask,
// corrects the codeword, reports the error position and counts corrected beats.
module hamming_syndrome_fix_pipe #(
    parameter int SYN_W = 4,
    parameter int CNT_W = 16
) (
    input logic                        clk,
    input logic                        rst_n,
    hamming_syndrome_fix_pipe_if.slave bus
);
    localparam int CW_W = (1 << SYN_W) - 1;

    generate
        if (SYN_W < 2 || SYN_W > 6) begin : g_bad_syn_w
            $error("hamming_syndrome_fix_pipe: SYN_W must lie within 2..6");
        end
    endgenerate

    logic             s1_valid_reg,  s1_valid_next;
    logic             s1_bypass_reg, s1_bypass_next;
    logic [CW_W:1]    s1_cw_reg,     s1_cw_next;
    logic [SYN_W-1:0] s1_syn_reg,    s1_syn_next;
    logic [CW_W:1]    s1_mask_reg,   s1_mask_next;

    logic             s2_valid_reg,  s2_valid_next;
    logic [CW_W:1]    s2_cw_reg,     s2_cw_next;
    logic             s2_err_reg,    s2_err_next;
    logic [SYN_W-1:0] s2_pos_reg,    s2_pos_next;

    logic [CNT_W-1:0] count_reg,     count_next;

    logic [CW_W:1]    mask_dec;
    logic             s2_load;
    logic             in_ready_int;
    logic             in_fire;
    logic             out_fire;
    logic             count_inc;

    // Bit k of the mask addresses codeword bit k; syndrome 0 leaves every bit clear.
    genvar gi;
    generate
        for (gi = 1; gi <= CW_W; gi++) begin : g_mask
            assign mask_dec[gi] = (bus.in_syndrome == SYN_W'(gi));
        end
    endgenerate

    // in_ready looks straight through to out_ready, so a full pipe drains and refills in one cycle.
    assign s2_load      = !s2_valid_reg || bus.out_ready;
    assign in_ready_int = !s1_valid_reg || s2_load;
    assign in_fire      = bus.in_valid && in_ready_int;
    assign out_fire     = s2_valid_reg && bus.out_ready;
    assign count_inc    = out_fire && s2_err_reg;

    always_comb begin
        s1_valid_next  = s1_valid_reg;
        s1_bypass_next = s1_bypass_reg;
        s1_cw_next     = s1_cw_reg;
        s1_syn_next    = s1_syn_reg;
        s1_mask_next   = s1_mask_reg;
        if (in_ready_int) begin
            s1_valid_next = bus.in_valid;
        end
        if (in_fire) begin
            s1_bypass_next = bus.in_bypass;
            s1_cw_next     = bus.in_codeword;
            s1_syn_next    = bus.in_syndrome;
            s1_mask_next   = mask_dec;
        end
    end

    // Data registers only move on a real beat, so a stalled output holds its value.
    always_comb begin
        s2_valid_next = s2_valid_reg;
        s2_cw_next    = s2_cw_reg;
        s2_err_next   = s2_err_reg;
        s2_pos_next   = s2_pos_reg;
        if (s2_load) begin
            s2_valid_next = s1_valid_reg;
            if (s1_valid_reg) begin
                s2_cw_next  = s1_bypass_reg ? s1_cw_reg : (s1_cw_reg ^ s1_mask_reg);
                s2_err_next = |s1_syn_reg;
                s2_pos_next = s1_syn_reg;
            end
        end
    end

    // Clear has priority over a same-cycle increment; the count sticks at all-ones.
    always_comb begin
        count_next = count_reg;
        if (bus.clr_count) begin
            count_next = '0;
        end else if (count_inc && (count_reg != {CNT_W{1'b1}})) begin
            count_next = count_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg  <= 1'b0;
            s1_bypass_reg <= 1'b0;
            s1_cw_reg     <= '0;
            s1_syn_reg    <= '0;
            s1_mask_reg   <= '0;
            s2_valid_reg  <= 1'b0;
            s2_cw_reg     <= '0;
            s2_err_reg    <= 1'b0;
            s2_pos_reg    <= '0;
            count_reg     <= '0;
        end else begin
            s1_valid_reg  <= s1_valid_next;
            s1_bypass_reg <= s1_bypass_next;
            s1_cw_reg     <= s1_cw_next;
            s1_syn_reg    <= s1_syn_next;
            s1_mask_reg   <= s1_mask_next;
            s2_valid_reg  <= s2_valid_next;
            s2_cw_reg     <= s2_cw_next;
            s2_err_reg    <= s2_err_next;
            s2_pos_reg    <= s2_pos_next;
            count_reg     <= count_next;
        end
    end

    assign bus.in_ready     = in_ready_int;
    assign bus.out_valid    = s2_valid_reg;
    assign bus.out_codeword = s2_cw_reg;
    assign bus.out_err      = s2_err_reg;
    assign bus.out_err_pos  = s2_pos_reg;
    assign bus.err_count    = count_reg;
endmodule

// File: tb/tb_hamming_syndrome_fix_pipe.sv
// Directed bench for hamming_syndrome_fix_pipe: default build, a 2-bit counter build
// and a SYN_W=3 build share one clock and reset.
module tb_hamming_syndrome_fix_pipe;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    hamming_syndrome_fix_pipe_if #(.SYN_W(4), .CNT_W(16)) if4 ();
    hamming_syndrome_fix_pipe_if #(.SYN_W(4), .CNT_W(2))  ifc ();
    hamming_syndrome_fix_pipe_if #(.SYN_W(3), .CNT_W(16)) if3 ();

    hamming_syndrome_fix_pipe #(.SYN_W(4), .CNT_W(16)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
    hamming_syndrome_fix_pipe #(.SYN_W(4), .CNT_W(2))  u_dutc (.clk(clk), .rst_n(rst_n), .bus(ifc));
    hamming_syndrome_fix_pipe #(.SYN_W(3), .CNT_W(16)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if4.in_valid = 0; if4.in_codeword = '0; if4.in_syndrome = '0; if4.in_bypass = 0;
        if4.out_ready = 1; if4.clr_count = 0;
        ifc.in_valid = 0; ifc.in_codeword = '0; ifc.in_syndrome = '0; ifc.in_bypass = 0;
        ifc.out_ready = 1; ifc.clr_count = 0;
        if3.in_valid = 0; if3.in_codeword = '0; if3.in_syndrome = '0; if3.in_bypass = 0;
        if3.out_ready = 1; if3.clr_count = 0;
        repeat (3) @(posedge clk);
        #4 rst_n = 1'b1;
        tick();
        checks++; if (if4.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0h want 0", if4.out_valid); end
        checks++; if (if4.out_codeword !== 15'h0) begin errors++; $display("FAIL rst_out_codeword got %0h want 0", if4.out_codeword); end
        checks++; if (if4.out_err !== 1'b0) begin errors++; $display("FAIL rst_out_err got %0h want 0", if4.out_err); end
        checks++; if (if4.out_err_pos !== 4'h0) begin errors++; $display("FAIL rst_out_err_pos got %0h want 0", if4.out_err_pos); end
        checks++; if (if4.err_count !== 16'h0) begin errors++; $display("FAIL rst_err_count got %0h want 0", if4.err_count); end
        checks++; if (if4.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0h want 1", if4.in_ready); end
    endtask

    task automatic test_single();
        if4.out_ready = 1; if4.in_valid = 1; if4.in_codeword = 15'h1234; if4.in_syndrome = 4'd0;
        tick();
        if4.in_valid = 0;
        checks++; if (if4.out_valid !== 1'b0) begin errors++; $display("FAIL single_latency1 got %0h want 0", if4.out_valid); end
        tick();
        checks++; if (if4.out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got %0h want 1", if4.out_valid); end
        checks++; if (if4.out_codeword !== 15'h1234) begin errors++; $display("FAIL single_codeword got %0h want 1234", if4.out_codeword); end
        checks++; if (if4.out_err !== 1'b0) begin errors++; $display("FAIL single_err got %0h want 0", if4.out_err); end
        checks++; if (if4.out_err_pos !== 4'h0) begin errors++; $display("FAIL single_pos got %0h want 0", if4.out_err_pos); end
        tick();
        checks++; if (if4.out_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %0h want 0", if4.out_valid); end
        checks++; if (if4.err_count !== 16'd0) begin errors++; $display("FAIL single_count got %0d want 0", if4.err_count); end
    endtask

    task automatic test_all_syndromes();
        int sent;
        int got;
        logic [15:1] exp_cw;
        sent = 0;
        got  = 0;
        if4.out_ready = 1;
        for (int c = 0; c < 40 && got < 15; c++) begin
            if4.in_valid    = (sent < 15);
            if4.in_codeword = '0;
            if4.in_syndrome = 4'(sent + 1);
            #1;
            if (if4.out_valid) begin
                exp_cw = 15'd1 << got;
                checks++; if (if4.out_codeword !== exp_cw) begin errors++; $display("FAIL syn%0d_codeword got %0h want %0h", got + 1, if4.out_codeword, exp_cw); end
                checks++; if (if4.out_err_pos !== 4'(got + 1)) begin errors++; $display("FAIL syn%0d_pos got %0d want %0d", got + 1, if4.out_err_pos, got + 1); end
                checks++; if (if4.out_err !== 1'b1) begin errors++; $display("FAIL syn%0d_err got %0h want 1", got + 1, if4.out_err); end
                got++;
            end
            if (if4.in_valid && if4.in_ready) sent++;
            tick();
        end
        if4.in_valid = 0;
        checks++; if (got != 15) begin errors++; $display("FAIL syn_beats got %0d want 15", got); end
        checks++; if (if4.err_count !== 16'd15) begin errors++; $display("FAIL syn_count got %0d want 15", if4.err_count); end
    endtask

    task automatic test_back_to_back();
        logic [15:1] b_cw [8];
        logic [15:1] b_exp[8];
        logic [3:0]  b_syn[8];
        logic [15:1] prev_cw;
        logic        prev_err;
        logic [3:0]  prev_pos;
        logic        stalled_prev;
        logic        saw_not_ready;
        int          sent;
        int          got;
        b_cw[0] = 15'h0001; b_syn[0] = 4'd1;  b_exp[0] = 15'h0000;
        b_cw[1] = 15'h0000; b_syn[1] = 4'd0;  b_exp[1] = 15'h0000;
        b_cw[2] = 15'h7FFF; b_syn[2] = 4'd15; b_exp[2] = 15'h3FFF;
        b_cw[3] = 15'h1234; b_syn[3] = 4'd3;  b_exp[3] = 15'h1230;
        b_cw[4] = 15'h5555; b_syn[4] = 4'd2;  b_exp[4] = 15'h5557;
        b_cw[5] = 15'h2AAA; b_syn[5] = 4'd8;  b_exp[5] = 15'h2A2A;
        b_cw[6] = 15'h0F0F; b_syn[6] = 4'd12; b_exp[6] = 15'h070F;
        b_cw[7] = 15'h4000; b_syn[7] = 4'd15; b_exp[7] = 15'h0000;
        sent = 0; got = 0; stalled_prev = 0; saw_not_ready = 0;
        prev_cw = '0; prev_err = 0; prev_pos = '0;
        for (int c = 0; c < 60 && got < 8; c++) begin
            if4.out_ready = !(c >= 5 && c <= 7);
            if4.in_valid  = (sent < 8);
            if (sent < 8) begin
                if4.in_codeword = b_cw[sent];
                if4.in_syndrome = b_syn[sent];
            end
            #1;
            if (stalled_prev) begin
                checks++; if (if4.out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid c%0d got %0h want 1", c, if4.out_valid); end
                checks++; if (if4.out_codeword !== prev_cw) begin errors++; $display("FAIL stall_codeword c%0d got %0h want %0h", c, if4.out_codeword, prev_cw); end
                checks++; if ({if4.out_err, if4.out_err_pos} !== {prev_err, prev_pos}) begin errors++; $display("FAIL stall_err c%0d got %0h/%0d want %0h/%0d", c, if4.out_err, if4.out_err_pos, prev_err, prev_pos); end
            end
            if (!if4.in_ready) saw_not_ready = 1;
            if (if4.out_valid && if4.out_ready) begin
                checks++; if (if4.out_codeword !== b_exp[got]) begin errors++; $display("FAIL b2b%0d_codeword got %0h want %0h", got, if4.out_codeword, b_exp[got]); end
                checks++; if (if4.out_err_pos !== b_syn[got]) begin errors++; $display("FAIL b2b%0d_pos got %0d want %0d", got, if4.out_err_pos, b_syn[got]); end
                checks++; if (if4.out_err !== (b_syn[got] != 4'd0)) begin errors++; $display("FAIL b2b%0d_err got %0h want %0h", got, if4.out_err, (b_syn[got] != 4'd0)); end
                got++;
            end
            stalled_prev = if4.out_valid && !if4.out_ready;
            prev_cw  = if4.out_codeword;
            prev_err = if4.out_err;
            prev_pos = if4.out_err_pos;
            if (if4.in_valid && if4.in_ready) sent++;
            tick();
        end
        if4.in_valid = 0; if4.out_ready = 1;
        checks++; if (got != 8) begin errors++; $display("FAIL b2b_beats got %0d want 8", got); end
        checks++; if (saw_not_ready != 1'b1) begin errors++; $display("FAIL b2b_in_ready_drop got %0h want 1", saw_not_ready); end
        checks++; if (if4.err_count !== 16'd22) begin errors++; $display("FAIL b2b_count got %0d want 22", if4.err_count); end
    endtask

    task automatic test_bypass();
        if4.out_ready = 1; if4.in_valid = 1; if4.in_codeword = 15'h7FFF; if4.in_syndrome = 4'd5; if4.in_bypass = 1;
        tick();
        if4.in_valid = 0; if4.in_bypass = 0;
        tick();
        checks++; if (if4.out_valid !== 1'b1) begin errors++; $display("FAIL bypass_valid got %0h want 1", if4.out_valid); end
        checks++; if (if4.out_codeword !== 15'h7FFF) begin errors++; $display("FAIL bypass_codeword got %0h want 7fff", if4.out_codeword); end
        checks++; if (if4.out_err !== 1'b1) begin errors++; $display("FAIL bypass_err got %0h want 1", if4.out_err); end
        checks++; if (if4.out_err_pos !== 4'd5) begin errors++; $display("FAIL bypass_pos got %0d want 5", if4.out_err_pos); end
        tick();
        checks++; if (if4.err_count !== 16'd23) begin errors++; $display("FAIL bypass_count got %0d want 23", if4.err_count); end
    endtask

    task automatic test_saturate();
        logic [1:0] exp_cnt[5];
        exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
        ifc.out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            ifc.in_valid = 1; ifc.in_codeword = '0; ifc.in_syndrome = 4'(i + 1);
            tick();
            ifc.in_valid = 0;
            tick();
            tick();
            checks++; if (ifc.err_count !== exp_cnt[i]) begin errors++; $display("FAIL sat_beat%0d_count got %0d want %0d", i, ifc.err_count, exp_cnt[i]); end
        end
        ifc.in_valid = 1; ifc.in_syndrome = 4'd9;
        tick();
        ifc.in_valid = 0;
        tick();
        checks++; if (ifc.out_valid !== 1'b1) begin errors++; $display("FAIL clr_beat_valid got %0h want 1", ifc.out_valid); end
        ifc.clr_count = 1;
        tick();
        ifc.clr_count = 0;
        checks++; if (ifc.err_count !== 2'd0) begin errors++; $display("FAIL clr_wins_count got %0d want 0", ifc.err_count); end
    endtask

    task automatic test_reset_mid_stream();
        logic [7:1] r_cw [3];
        logic [2:0] r_syn[3];
        logic [7:1] r_exp[3];
        int sent;
        int got;
        r_cw[0] = 7'h00; r_syn[0] = 3'd6; r_exp[0] = 7'h20;
        r_cw[1] = 7'h7F; r_syn[1] = 3'd7; r_exp[1] = 7'h3F;
        r_cw[2] = 7'h55; r_syn[2] = 3'd0; r_exp[2] = 7'h55;
        sent = 0; got = 0;
        if3.out_ready = 1;
        for (int c = 0; c < 20 && got < 3; c++) begin
            if3.in_valid = (sent < 3);
            if (sent < 3) begin
                if3.in_codeword = r_cw[sent];
                if3.in_syndrome = r_syn[sent];
            end
            #1;
            if (if3.out_valid) begin
                checks++; if (if3.out_codeword !== r_exp[got]) begin errors++; $display("FAIL s3_%0d_codeword got %0h want %0h", got, if3.out_codeword, r_exp[got]); end
                checks++; if (if3.out_err_pos !== r_syn[got]) begin errors++; $display("FAIL s3_%0d_pos got %0d want %0d", got, if3.out_err_pos, r_syn[got]); end
                got++;
            end
            if (if3.in_valid && if3.in_ready) sent++;
            tick();
        end
        if3.in_valid = 0;
        checks++; if (got != 3) begin errors++; $display("FAIL s3_beats got %0d want 3", got); end
        checks++; if (if3.err_count !== 16'd2) begin errors++; $display("FAIL s3_count got %0d want 2", if3.err_count); end
        if3.out_ready = 0; if3.in_valid = 1; if3.in_codeword = 7'h11; if3.in_syndrome = 3'd1;
        tick();
        if3.in_codeword = 7'h22; if3.in_syndrome = 3'd2;
        tick();
        if3.in_valid = 0;
        checks++; if (if3.out_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid got %0h want 1", if3.out_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (if3.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_async_valid got %0h want 0", if3.out_valid); end
        checks++; if (if3.err_count !== 16'd0) begin errors++; $display("FAIL midrst_count got %0d want 0", if3.err_count); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        if3.out_ready = 1;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++; if (if3.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_post%0d_valid got %0h want 0", c, if3.out_valid); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_all_syndromes();
        test_back_to_back();
        test_bypass();
        test_saturate();
        test_reset_mid_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end
endmodule
